delay_tap_mixer: RTL and testbench

- Sits directly downstream of the four fixed-length delay lines (30/45/60/90 samples).
- Selects one delayed tap as the "wet" signal and blends it with the undelayed "dry" input sample at a programmable gain.
- On a tap change, it ramps the wet gain down to zero, switches the tap, then ramps back up, so there is no audible step.
- Drives the top-level output bus with a registered, valid-qualified sample.

---
 rtl/delay_mix_pkg.sv | 18 +
 rtl/delay_tap_mixer_if.sv | 25 ++
 rtl/delay_mix_datapath.sv | 59 +++++
 rtl/delay_tap_mixer.sv | 127 ++++++++++++
 tb/tb_delay_tap_mixer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/delay_mix_pkg.sv
// Shared constants, crossfade state encoding and gain clamp for the delay tap mixer.
package delay_mix_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int GAIN_FULL  = 16;
    localparam int GAIN_W     = 5;

    typedef enum logic [1:0] {
        STEADY   = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2
    } mix_state_e;

    function automatic logic [GAIN_W-1:0] clamp16(input logic [GAIN_W-1:0] gain);
        return (gain > GAIN_W'(GAIN_FULL)) ? GAIN_W'(GAIN_FULL) : gain;
    endfunction

endpackage

// File: rtl/delay_tap_mixer_if.sv
// Sample bus between the delay lines, the mixer and the output stage.
interface delay_tap_mixer_if
    import delay_mix_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic                sample_valid;
    logic [DATA_W-1:0]   dry;
    logic [4*DATA_W-1:0] taps;
    logic [1:0]          tap_sel;
    logic [GAIN_W-1:0]   mix_gain;
    logic [DATA_W-1:0]   out;
    logic                out_valid;
    logic                fade_busy;

    modport master (
        output sample_valid, dry, taps, tap_sel, mix_gain,
        input  out, out_valid, fade_busy
    );

    modport slave (
        input  sample_valid, dry, taps, tap_sel, mix_gain,
        output out, out_valid, fade_busy
    );
endinterface

// File: rtl/delay_mix_datapath.sv
// Two-stage dry/wet blend: S1 captures dry/wet/gain, S2 registers the rounded weighted sum.
// Latency 2 cycles valid->out_valid; no backpressure, accepts one sample every cycle.
module delay_mix_datapath
    import delay_mix_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid,
    input  logic [DATA_W-1:0] dry,
    input  logic [DATA_W-1:0] wet,
    input  logic [GAIN_W-1:0] g,
    output logic [DATA_W-1:0] out,
    output logic              out_valid
);
    localparam int SUM_W = DATA_W + 5;

    logic              s1_vld;
    logic [DATA_W-1:0] s1_dry;
    logic [DATA_W-1:0] s1_wet;
    logic [GAIN_W-1:0] s1_g;
    logic [SUM_W-1:0]  dry_term;
    logic [SUM_W-1:0]  wet_term;
    logic [SUM_W-1:0]  mix_sum;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_vld <= 1'b0;
            s1_dry <= '0;
            s1_wet <= '0;
            s1_g   <= '0;
        end else begin
            s1_vld <= valid;
            if (valid) begin
                s1_dry <= dry;
                s1_wet <= wet;
                s1_g   <= g;
            end
        end
    end

    // Weights sum to 16, so the rounded result always fits back into DATA_W bits.
    assign dry_term = SUM_W'(s1_dry) * SUM_W'(GAIN_W'(GAIN_FULL) - s1_g);
    assign wet_term = SUM_W'(s1_wet) * SUM_W'(s1_g);
    assign mix_sum  = dry_term + wet_term + SUM_W'(8);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out       <= '0;
        end else begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                out <= DATA_W'(mix_sum >> 4);
            end
        end
    end
endmodule

// File: rtl/delay_tap_mixer.sv
// Tap select + dry/wet blend; DELAY_MIX_FADE_EN adds a gain crossfade on tap change.
// Latency 2 cycles sample_valid->out_valid; no backpressure, one sample per cycle.
module delay_tap_mixer
    import delay_mix_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int FADE_STEP = 1
) (
    input  logic              clock,
    input  logic              reset,
    delay_tap_mixer_if.slave  bus
);
    logic [GAIN_W-1:0] cur_gain;
    logic [GAIN_W-1:0] target;
    logic [1:0]        act_tap;
    logic [DATA_W-1:0] wet;
    logic [DATA_W-1:0] dp_out;
    logic              dp_out_valid;

    assign target = clamp16(bus.mix_gain);
    assign wet    = bus.taps[act_tap*DATA_W +: DATA_W];

`ifdef DELAY_MIX_FADE_EN
    localparam logic [GAIN_W-1:0] STEP_G = GAIN_W'(FADE_STEP);

    mix_state_e        state;
    mix_state_e        state_nxt;
    logic [GAIN_W-1:0] gain_toward;
    logic [GAIN_W-1:0] gain_down;
    logic [GAIN_W-1:0] gain_nxt;
    logic [1:0]        tap_nxt;
    logic              fade_busy_r;

    always_comb begin
        gain_toward = cur_gain;
        if (cur_gain < target) begin
            gain_toward = (target - cur_gain > STEP_G) ? cur_gain + STEP_G : target;
        end else if (cur_gain > target) begin
            gain_toward = (cur_gain - target > STEP_G) ? cur_gain - STEP_G : target;
        end
        gain_down = (cur_gain > STEP_G) ? cur_gain - STEP_G : '0;
    end

    always_comb begin
        state_nxt = state;
        gain_nxt  = cur_gain;
        tap_nxt   = act_tap;
        case (state)
            STEADY: begin
                if (bus.tap_sel != act_tap) begin
                    state_nxt = FADE_OUT;
                end else begin
                    gain_nxt = gain_toward;
                end
            end
            FADE_OUT: begin
                // The gain-0 sample still uses the old tap; the switch lands after it.
                if (cur_gain == '0) begin
                    tap_nxt   = bus.tap_sel;
                    state_nxt = FADE_IN;
                end else begin
                    gain_nxt = gain_down;
                    if (bus.tap_sel == act_tap) begin
                        state_nxt = FADE_IN;
                    end
                end
            end
            FADE_IN: begin
                if (bus.tap_sel != act_tap) begin
                    state_nxt = FADE_OUT;
                end else begin
                    gain_nxt = gain_toward;
                    if (gain_toward == target) begin
                        state_nxt = STEADY;
                    end
                end
            end
            default: state_nxt = STEADY;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= STEADY;
            cur_gain    <= '0;
            act_tap     <= '0;
            fade_busy_r <= 1'b0;
        end else if (bus.sample_valid) begin
            state       <= state_nxt;
            cur_gain    <= gain_nxt;
            act_tap     <= tap_nxt;
            fade_busy_r <= (state_nxt != STEADY);
        end
    end

    assign bus.fade_busy = fade_busy_r;
`else
    // Tap and gain jump straight to the request; they take effect from the next sample.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_gain <= '0;
            act_tap  <= '0;
        end else if (bus.sample_valid) begin
            cur_gain <= target;
            act_tap  <= bus.tap_sel;
        end
    end

    assign bus.fade_busy = 1'b0;
`endif

    delay_mix_datapath #(
        .DATA_W (DATA_W)
    ) u_datapath (
        .clock     (clock),
        .reset     (reset),
        .valid     (bus.sample_valid),
        .dry       (bus.dry),
        .wet       (wet),
        .g         (cur_gain),
        .out       (dp_out),
        .out_valid (dp_out_valid)
    );

    assign bus.out       = dp_out;
    assign bus.out_valid = dp_out_valid;
endmodule

// File: tb/tb_delay_tap_mixer.sv
// Directed-vector bench for delay_tap_mixer (taps: 0=200, 1=60, 2=255, 3=40; FADE_STEP=4).
module tb_delay_tap_mixer;
    import delay_mix_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    delay_tap_mixer_if #(.DATA_W(8)) bus();

    delay_tap_mixer #(
        .DATA_W    (8),
        .FADE_STEP (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic       v;
        logic [7:0] dry;
        logic [1:0] sel;
        logic [4:0] gain;
        logic [7:0] exp_out;
        logic       exp_busy;
    } vec_t;

    localparam logic [31:0] TAPS = {8'd40, 8'd255, 8'd60, 8'd200};

    int         checks = 0;
    int         errors = 0;
    logic       prev_v;
    logic [7:0] prev_exp;
    logic [7:0] hold_out;
    vec_t       tbl[$];

    function automatic vec_t mk(input int v, input int dry, input int sel, input int gain,
                                input int exp_out, input int exp_busy);
        vec_t r;
        r.v        = v[0];
        r.dry      = dry[7:0];
        r.sel      = sel[1:0];
        r.gain     = gain[4:0];
        r.exp_out  = exp_out[7:0];
        r.exp_busy = exp_busy[0];
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t r);
        bus.sample_valid = r.v;
        bus.dry          = r.dry;
        bus.tap_sel      = r.sel;
        bus.mix_gain     = r.gain;
    endtask

    // Output after an edge belongs to the sample captured one edge earlier.
    task automatic apply(input vec_t r, input string tag);
        drive(r);
        @(posedge clock);
        #1;
        check({tag, " out_valid"}, int'(bus.out_valid), int'(prev_v));
        if (prev_v) hold_out = prev_exp;
        check({tag, " out"}, int'(bus.out), int'(hold_out));
        check({tag, " fade_busy"}, int'(bus.fade_busy), int'(r.exp_busy));
        prev_v = r.v;
        if (r.v) prev_exp = r.exp_out;
    endtask

    initial begin
        reset            = 1'b1;
        bus.taps         = TAPS;
        bus.sample_valid = 1'b0;
        bus.dry          = '0;
        bus.tap_sel      = '0;
        bus.mix_gain     = '0;
        prev_v           = 1'b0;
        prev_exp         = '0;
        hold_out         = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset out", int'(bus.out), 0);
        check("reset out_valid", int'(bus.out_valid), 0);
        check("reset fade_busy", int'(bus.fade_busy), 0);
        @(negedge clock);
        reset = 1'b0;

`ifdef DELAY_MIX_FADE_EN
        // ramp up on tap 0, then blend at 8 and 16
        tbl.push_back(mk(1, 100, 0,  8, 100, 0));
        tbl.push_back(mk(1, 100, 0,  8, 125, 0));
        tbl.push_back(mk(1, 100, 0,  8, 150, 0));
        tbl.push_back(mk(1, 100, 0, 16, 150, 0));
        tbl.push_back(mk(1, 100, 0, 16, 175, 0));
        tbl.push_back(mk(1, 100, 0, 16, 200, 0));
        // request tap 2, reverse at gain 8
        tbl.push_back(mk(1, 100, 2, 16, 200, 1));
        tbl.push_back(mk(1, 100, 2, 16, 200, 1));
        tbl.push_back(mk(1, 100, 2, 16, 175, 1));
        tbl.push_back(mk(1, 100, 0, 16, 150, 1));
        tbl.push_back(mk(1, 100, 0, 16, 125, 1));
        tbl.push_back(mk(1, 100, 0, 16, 150, 1));
        tbl.push_back(mk(1, 100, 0, 16, 175, 0));
        tbl.push_back(mk(1, 100, 0, 16, 200, 0));
        // full crossfade to tap 2
        tbl.push_back(mk(1, 100, 2, 16, 200, 1));
        tbl.push_back(mk(1, 100, 2, 16, 200, 1));
        tbl.push_back(mk(1, 100, 2, 16, 175, 1));
        tbl.push_back(mk(1, 100, 2, 16, 150, 1));
        tbl.push_back(mk(1, 100, 2, 16, 125, 1));
        tbl.push_back(mk(1, 100, 2, 16, 100, 1));
        tbl.push_back(mk(1, 100, 2, 16, 100, 1));
        tbl.push_back(mk(1, 100, 2, 16, 139, 1));
        tbl.push_back(mk(1, 100, 2, 16, 178, 1));
        tbl.push_back(mk(1, 100, 2, 16, 216, 0));
        tbl.push_back(mk(1, 100, 2, 16, 255, 0));
        // clamp and zero-gain boundaries
        tbl.push_back(mk(1,   0, 2, 31, 255, 0));
        tbl.push_back(mk(1, 100, 2,  0, 255, 0));
        tbl.push_back(mk(1, 100, 2,  0, 216, 0));
        tbl.push_back(mk(1, 100, 2,  0, 178, 0));
        tbl.push_back(mk(1, 100, 2,  0, 139, 0));
        tbl.push_back(mk(1, 100, 2,  0, 100, 0));
        // gaps 1,0,0,1
        tbl.push_back(mk(1, 100, 2,  8, 100, 0));
        tbl.push_back(mk(0, 100, 2,  8,   0, 0));
        tbl.push_back(mk(0, 100, 2,  8,   0, 0));
        tbl.push_back(mk(1, 100, 2,  8, 139, 0));
        tbl.push_back(mk(1, 100, 2,  8, 178, 0));
        tbl.push_back(mk(0, 100, 2,  8,   0, 0));
`else
        tbl.push_back(mk(1, 100, 0,  8, 100, 0));
        tbl.push_back(mk(1, 100, 0,  8, 150, 0));
        tbl.push_back(mk(1, 100, 2,  8, 150, 0));
        tbl.push_back(mk(1, 100, 2, 16, 178, 0));
        tbl.push_back(mk(1,   0, 2, 31, 255, 0));
        tbl.push_back(mk(1,   0, 2,  0, 255, 0));
        tbl.push_back(mk(1,  77, 1,  4,  77, 0));
        tbl.push_back(mk(0,  77, 1,  4,   0, 0));
        tbl.push_back(mk(0,  77, 1,  4,   0, 0));
        tbl.push_back(mk(1,  50, 3,  0,  53, 0));
        tbl.push_back(mk(1,  50, 3, 12,  50, 0));
        tbl.push_back(mk(1,  10, 3, 12,  33, 0));
        tbl.push_back(mk(1, 255, 0, 16,  94, 0));
        tbl.push_back(mk(1,   0, 0, 16, 200, 0));
        tbl.push_back(mk(0,   0, 0, 16,   0, 0));
`endif
        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // reset in the middle of a fade (FADE_IN in the crossfade build)
        drive(mk(1, 100, 3, 16, 0, 0));
        @(posedge clock);
        drive(mk(1, 100, 2, 16, 0, 0));
        @(posedge clock);
        #1;
`ifdef DELAY_MIX_FADE_EN
        check("pre-reset fade_busy", int'(bus.fade_busy), 1);
`endif
        check("pre-reset out_valid", int'(bus.out_valid), 1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("async reset out", int'(bus.out), 0);
        check("async reset out_valid", int'(bus.out_valid), 0);
        check("async reset fade_busy", int'(bus.fade_busy), 0);
        @(posedge clock);
        @(negedge clock);
        reset            = 1'b0;
        bus.sample_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clock);
            #1;
            check($sformatf("flush%0d out_valid", k), int'(bus.out_valid), 0);
        end
        prev_v   = 1'b0;
        hold_out = '0;
        apply(mk(1, 100, 0, 16, 100, 0), "post-reset0");
`ifdef DELAY_MIX_FADE_EN
        apply(mk(1, 100, 0, 16, 125, 0), "post-reset1");
`else
        apply(mk(1, 100, 0, 16, 200, 0), "post-reset1");
`endif
        apply(mk(0, 100, 0, 16, 0, 0), "post-reset2");
        apply(mk(0, 100, 0, 16, 0, 0), "post-reset3");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
